// File: rtl/cnn_bias_relu_stream.sv
// Per-output-channel bias add with saturation and ReLU on a channel-major pixel stream.
// Define CNN_BIAS_RELU6_EN to clamp positive results to 6.0 (ReLU6) instead of plain ReLU.
module cnn_bias_relu_stream #(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 8,
    parameter int IMAGE_SIZE      = 4096,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int PXL_CNT_WIDTH   = 12,
    parameter int CH_CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  bias_reload,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  bias_ready,
    output logic                  err_drop
);

`ifdef CNN_BIAS_RELU6_EN
    localparam bit RELU6 = 1'b1;
`else
    localparam bit RELU6 = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    // Upper clamp collapses to MAX_POS (a no-op after saturation) when ReLU6 is off.
    localparam logic [DATA_WIDTH-1:0] CLAMP   = RELU6 ? DATA_WIDTH'(6 << FRAC_BITS) : MAX_POS;

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t state, state_nx;

    logic [CH_CNT_WIDTH-1:0]  ptr;
    logic [PXL_CNT_WIDTH-1:0] pxl_cnt;
    logic [CH_CNT_WIDTH-1:0]  ch_cnt;
    logic                     reload_pend;

    logic [DATA_WIDTH-1:0] bias_mem [0:CHANNEL_NUM_OUT-1];

    logic                  v1, last1;
    logic [DATA_WIDTH-1:0] p1, b1;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] res;

    logic bias_wr, accept, ptr_last, pxl_wrap, ch_wrap, last_pix, at_frame_start;

    assign bias_wr        = (state == S_LOAD) && valid_bias_in;
    assign accept         = (state == S_RUN) && valid_in;
    assign ptr_last       = (ptr == CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1));
    assign pxl_wrap       = (pxl_cnt == PXL_CNT_WIDTH'(IMAGE_SIZE - 1));
    assign ch_wrap        = (ch_cnt == CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1));
    assign last_pix       = accept && pxl_wrap && ch_wrap;
    assign at_frame_start = (pxl_cnt == '0) && (ch_cnt == '0);
    assign bias_ready     = (state == S_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: if (bias_wr && ptr_last) state_nx = S_RUN;
            S_RUN: begin
                // A pending or coincident reload takes effect once the last pixel is accepted.
                if (last_pix && (reload_pend || bias_reload))
                    state_nx = S_LOAD;
                else if (bias_reload && !valid_in && at_frame_start)
                    state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            pxl_cnt     <= '0;
            ch_cnt      <= '0;
            reload_pend <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            if (bias_wr)
                ptr <= ptr_last ? '0 : ptr + CH_CNT_WIDTH'(1);
            if (accept) begin
                if (pxl_wrap) begin
                    pxl_cnt <= '0;
                    ch_cnt  <= ch_wrap ? '0 : ch_cnt + CH_CNT_WIDTH'(1);
                end else begin
                    pxl_cnt <= pxl_cnt + PXL_CNT_WIDTH'(1);
                end
            end
            if (state == S_RUN) begin
                if (state_nx == S_LOAD) reload_pend <= 1'b0;
                else if (bias_reload)   reload_pend <= 1'b1;
            end
            if ((state == S_LOAD) && valid_in)
                err_drop <= 1'b1;
        end
    end

    // Bias storage and its synchronous read port carry no reset.
    always_ff @(posedge clk) begin
        if (bias_wr)
            bias_mem[ptr] <= bias_in;
        b1 <= bias_mem[ch_cnt];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            p1    <= '0;
        end else begin
            v1    <= accept;
            last1 <= last_pix;
            p1    <= pxl_in;
        end
    end

    always_comb begin
        sum = {p1[DATA_WIDTH-1], p1} + {b1[DATA_WIDTH-1], b1};
        res = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH])
            res = '0;
        else if (sum[DATA_WIDTH-1])
            res = MAX_POS;
        if (res > CLAMP)
            res = CLAMP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= v1;
            frame_done <= v1 && last1;
            if (v1)
                pxl_out <= res;
        end
    end

endmodule
